// File: rtl/wb_stage_ld_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ld_pkg
// Purpose  : Shared encodings for the load-capable writeback stage:
//            memory access types, load sizes, FSM states and a helper
//            for sizing the load-wait counter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_stage_ld_pkg;

  // Access type codes produced by step_mm
  localparam logic [1:0] c_MEM_ACCESS_TYPE_NONE = 2'd0;
  localparam logic [1:0] c_MEM_ACCESS_TYPE_R2R  = 2'd1;
  localparam logic [1:0] c_MEM_ACCESS_TYPE_M2R  = 2'd2;
  localparam logic [1:0] c_MEM_ACCESS_TYPE_R2M  = 2'd3;

  // Load size codes; the reserved code behaves as a word access
  localparam logic [1:0] c_MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] c_MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] c_MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] c_MEM_SIZE_RSVD = 2'd3;

  // Writeback FSM states
  typedef enum logic [0:0] {
    WB_ST_IDLE = 1'b0,
    WB_ST_WAIT = 1'b1
  } wb_state_e;

  // Width of the load-wait counter: enough to hold the limit, never below 8 bits
  function automatic int unsigned wb_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_ld_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ld_if
// Purpose  : Bundles the MM/WB input bus, register-file write port,
//            forwarding port and status signals of the writeback stage.
//            master = pipeline/environment side, slave = writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_ld_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  // Control from the pipeline
  logic                  stall_i;
  logic                  flush_i;
  // Instruction fields from step_mm
  logic [1:0]            mem_access_type;
  logic [1:0]            mem_size;
  logic                  mem_sign_ext;
  logic [1:0]            addr_lo;
  logic [DATA_W-1:0]     alu_data_i;
  logic [REG_ADDR_W-1:0] bypass_reg_addr_mm;
  // Memory read return
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rdata_valid;
  // Register-file write port
  logic                  reg_write_enable;
  logic [REG_ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0]     reg_write_data;
  // Forwarding port to EX
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
  // Status
  logic                  wb_busy;
  logic                  misalign_err;
  logic                  load_timeout;

  modport master (
    output stall_i, flush_i, mem_access_type, mem_size, mem_sign_ext, addr_lo,
           alu_data_i, bypass_reg_addr_mm, mem_rdata, mem_rdata_valid,
    input  reg_write_enable, reg_write_addr, reg_write_data,
           fwd_valid, fwd_addr, fwd_data, wb_busy, misalign_err, load_timeout
  );

  modport slave (
    input  stall_i, flush_i, mem_access_type, mem_size, mem_sign_ext, addr_lo,
           alu_data_i, bypass_reg_addr_mm, mem_rdata, mem_rdata_valid,
    output reg_write_enable, reg_write_addr, reg_write_data,
           fwd_valid, fwd_addr, fwd_data, wb_busy, misalign_err, load_timeout
  );

endinterface
`default_nettype wire

// File: rtl/wb_stage_ld_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_align
// Purpose  : Combinational load-data alignment for the writeback stage.
//            Picks the addressed byte/half out of a little-endian word,
//            zero- or sign-extends it, and flags misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_align
  import wb_stage_ld_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_sign_ext,
  input  logic [1:0]        i_addr_lo,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection, extension and alignment check
  always_comb begin
    w_byte       = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half       = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    o_data       = '0;
    o_misaligned = 1'b0;
    case (i_mem_size)
      c_MEM_SIZE_BYTE: begin
        o_data = {{(DATA_W-8){i_mem_sign_ext & w_byte[7]}}, w_byte};
      end
      c_MEM_SIZE_HALF: begin
        o_data       = {{(DATA_W-16){i_mem_sign_ext & w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      c_MEM_SIZE_WORD, c_MEM_SIZE_RSVD: begin
        o_data       = i_mem_rdata;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_ld.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_ld
// Purpose  : Registered MM/WB writeback stage with load alignment, a wait
//            state for late load data, single-shot register-file write,
//            forwarding port to EX and stall request upstream.
//            Optional macro WB_LOAD_TIMEOUT_EN adds a load-wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_ld
  import wb_stage_ld_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_stage_ld_if.slave bus
);

  // MM/WB latch
  logic                  r_valid;
  logic                  r_done;
  logic [1:0]            r_type;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [1:0]            r_addr_lo;
  logic [DATA_W-1:0]     r_alu;
  logic [REG_ADDR_W-1:0] r_rd;

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;

  logic [DATA_W-1:0]     w_ld_data;
  logic                  w_ld_misaligned;
  logic                  w_type_r2r;
  logic                  w_type_m2r;
  logic                  w_live;
  logic                  w_is_load;
  logic                  w_misalign;
  logic                  w_load_pending;
  logic                  w_fire;
  logic                  w_we;
  logic                  w_busy;
  logic                  w_latch_en;
  logic                  w_timeout;
  logic [DATA_W-1:0]     w_wdata;

  // Alignment works on the latched access shape and the live memory word
  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_mem_rdata    (bus.mem_rdata),
    .i_mem_size     (r_size),
    .i_mem_sign_ext (r_sign),
    .i_addr_lo      (r_addr_lo),
    .o_data         (w_ld_data),
    .o_misaligned   (w_ld_misaligned)
  );

  // Decode latched instruction into write / wait / error conditions
  always_comb begin
    w_type_r2r = 1'b0;
    w_type_m2r = 1'b0;
    case (r_type)
      c_MEM_ACCESS_TYPE_R2R: w_type_r2r = 1'b1;
      c_MEM_ACCESS_TYPE_M2R: w_type_m2r = 1'b1;
      c_MEM_ACCESS_TYPE_NONE, c_MEM_ACCESS_TYPE_R2M: ;
    endcase

    w_live         = r_valid && !r_done;
    w_is_load      = w_live && w_type_m2r;
    w_misalign     = w_is_load && w_ld_misaligned;
    w_load_pending = w_is_load && !w_ld_misaligned;

    // Flush beats late load data; timeout only fires with data absent
    w_fire = (w_live && w_type_r2r) ||
             (w_load_pending && bus.mem_rdata_valid && !bus.flush_i);
    // Register 0 is hardwired, so its writes are dropped but still consume the instruction
    w_we   = w_fire && (r_rd != '0);

    // Busy is raised in the very first cycle a load lacks data, so a fast load adds no bubble
    w_busy     = w_load_pending && !bus.mem_rdata_valid;
    w_latch_en = !bus.stall_i && !w_busy;

    w_wdata = w_type_r2r ? r_alu : w_ld_data;
  end

  // MM/WB latch: capture when free, otherwise hold and remember a completed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_type    <= c_MEM_ACCESS_TYPE_NONE;
      r_size    <= c_MEM_SIZE_BYTE;
      r_sign    <= 1'b0;
      r_addr_lo <= 2'b00;
      r_alu     <= '0;
      r_rd      <= '0;
    end else if (w_latch_en) begin
      r_valid   <= !bus.flush_i;
      r_done    <= 1'b0;
      r_type    <= bus.mem_access_type;
      r_size    <= bus.mem_size;
      r_sign    <= bus.mem_sign_ext;
      r_addr_lo <= bus.addr_lo;
      r_alu     <= bus.alu_data_i;
      r_rd      <= bus.bypass_reg_addr_mm;
    end else begin
      if (bus.flush_i) begin
        r_valid <= 1'b0;
      end
      if (w_fire || w_misalign || w_timeout) begin
        r_done <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WB_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: park in WAIT while a load's data is outstanding
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_ST_IDLE: begin
        if (w_load_pending && !bus.mem_rdata_valid && !bus.flush_i) begin
          w_state_nxt = WB_ST_WAIT;
        end
      end
      WB_ST_WAIT: begin
        if (!w_load_pending || bus.mem_rdata_valid || bus.flush_i || w_timeout) begin
          w_state_nxt = WB_ST_IDLE;
        end
      end
      default: w_state_nxt = WB_ST_IDLE;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned c_CNT_W = wb_cnt_width(TIMEOUT_CYC);

  logic [c_CNT_W-1:0] r_wait_cnt;

  // Counter holds the number of WAIT cycles already spent on this load
  assign w_timeout = (r_state == WB_ST_WAIT) && w_load_pending &&
                     !bus.mem_rdata_valid && !bus.flush_i &&
                     (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

  // Count consecutive WAIT cycles, clear whenever WAIT is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WB_ST_WAIT) && (w_state_nxt == WB_ST_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  // Without the timeout a load waits for its data indefinitely
  localparam int unsigned c_unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  // Write port and forwarding port carry identical values, zero when idle
  assign bus.reg_write_enable = w_we;
  assign bus.reg_write_addr   = w_we ? r_rd : '0;
  assign bus.reg_write_data   = w_we ? w_wdata : '0;
  assign bus.fwd_valid        = w_we;
  assign bus.fwd_addr         = w_we ? r_rd : '0;
  assign bus.fwd_data         = w_we ? w_wdata : '0;
  assign bus.wb_busy          = w_busy;
  assign bus.misalign_err     = w_misalign;
  assign bus.load_timeout     = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ld.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_ld
// Purpose  : Directed self-checking bench for wb_stage_ld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_ld;
  import wb_stage_ld_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  wb_stage_ld_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  wb_stage_ld #(
    .DATA_W      (32),
    .REG_ADDR_W  (5),
    .TIMEOUT_CYC (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and move off the edge before driving/checking
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [1:0] t, input logic [1:0] sz, input logic sx,
                         input logic [1:0] alo, input logic [31:0] alu, input logic [4:0] rd);
    bus.mem_access_type    = t;
    bus.mem_size           = sz;
    bus.mem_sign_ext       = sx;
    bus.addr_lo            = alo;
    bus.alu_data_i         = alu;
    bus.bypass_reg_addr_mm = rd;
  endtask

  task automatic idle_in();
    present(c_MEM_ACCESS_TYPE_NONE, c_MEM_SIZE_WORD, 1'b0, 2'b00, 32'h0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_rdata_valid = 1'b0;
    idle_in();

    // Reset state
    #3;
    chk("reset_we", bus.reg_write_enable, 1'b0);
    chk("reset_busy", bus.wb_busy, 1'b0);
    chk("reset_data", bus.reg_write_data, 32'h0);
    chk("reset_misalign", bus.misalign_err, 1'b0);
    chk("reset_timeout", bus.load_timeout, 1'b0);
    #9 rst_n = 1'b1;

    // R2R write to reg 5, one cycle only
    tick();
    present(c_MEM_ACCESS_TYPE_R2R, c_MEM_SIZE_WORD, 1'b0, 2'b00, 32'h1234_5678, 5'd5);
    tick();
    idle_in();
    #1;
    chk("r2r_we", bus.reg_write_enable, 1'b1);
    chk("r2r_addr", bus.reg_write_addr, 5'd5);
    chk("r2r_data", bus.reg_write_data, 32'h1234_5678);
    chk("r2r_fwd_valid", bus.fwd_valid, 1'b1);
    chk("r2r_fwd_addr", bus.fwd_addr, 5'd5);
    chk("r2r_fwd_data", bus.fwd_data, 32'h1234_5678);
    tick();
    chk("r2r_single_shot", bus.reg_write_enable, 1'b0);

    // Byte load, lane 3, sign-extended, data on time
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_BYTE, 1'b1, 2'd3, 32'h0, 5'd7);
    tick();
    idle_in();
    bus.mem_rdata = 32'h80FF_0000;
    bus.mem_rdata_valid = 1'b1;
    #1;
    chk("ldb_we", bus.reg_write_enable, 1'b1);
    chk("ldb_data", bus.reg_write_data, 32'hFFFF_FF80);
    chk("ldb_addr", bus.reg_write_addr, 5'd7);
    chk("ldb_busy", bus.wb_busy, 1'b0);
    tick();
    bus.mem_rdata_valid = 1'b0;

    // Half load, upper half, zero-extended
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_HALF, 1'b0, 2'd2, 32'h0, 5'd8);
    tick();
    idle_in();
    bus.mem_rdata_valid = 1'b1;
    #1;
    chk("ldh_we", bus.reg_write_enable, 1'b1);
    chk("ldh_data", bus.reg_write_data, 32'h0000_80FF);
    tick();
    bus.mem_rdata_valid = 1'b0;

    // Word load with 3 cycles of late data, then write under a held stall
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0, 5'd9);
    tick();
    idle_in();
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ldw_busy_c1", bus.wb_busy, 1'b1);
    chk("ldw_we_c1", bus.reg_write_enable, 1'b0);
    tick();
    chk("ldw_busy_c2", bus.wb_busy, 1'b1);
    tick();
    chk("ldw_busy_c3", bus.wb_busy, 1'b1);
    tick();
    bus.mem_rdata_valid = 1'b1;
    bus.stall_i = 1'b1;
    #1;
    chk("ldw_we", bus.reg_write_enable, 1'b1);
    chk("ldw_data", bus.reg_write_data, 32'hDEAD_BEEF);
    chk("ldw_busy_drop", bus.wb_busy, 1'b0);
    tick();
    chk("ldw_no_dup1", bus.reg_write_enable, 1'b0);
    tick();
    chk("ldw_no_dup2", bus.reg_write_enable, 1'b0);
    bus.stall_i = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    tick();

    // Misaligned half load
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_HALF, 1'b1, 2'd1, 32'h0, 5'd3);
    tick();
    idle_in();
    #1;
    chk("mis_err", bus.misalign_err, 1'b1);
    chk("mis_we", bus.reg_write_enable, 1'b0);
    chk("mis_busy", bus.wb_busy, 1'b0);
    tick();
    chk("mis_err_pulse", bus.misalign_err, 1'b0);

    // Misaligned word load
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd2, 32'h0, 5'd4);
    tick();
    idle_in();
    #1;
    chk("misw_err", bus.misalign_err, 1'b1);
    chk("misw_busy", bus.wb_busy, 1'b0);
    tick();

    // R2R to register 0 is suppressed
    present(c_MEM_ACCESS_TYPE_R2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0000_FFFF, 5'd0);
    tick();
    idle_in();
    #1;
    chk("r0_we", bus.reg_write_enable, 1'b0);
    chk("r0_fwd", bus.fwd_valid, 1'b0);
    tick();

    // R2M never writes
    present(c_MEM_ACCESS_TYPE_R2M, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'hAAAA_5555, 5'd6);
    tick();
    idle_in();
    #1;
    chk("r2m_we", bus.reg_write_enable, 1'b0);
    tick();

    // Flush while waiting for load data
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0, 5'd10);
    tick();
    idle_in();
    #1;
    chk("fl_busy_c1", bus.wb_busy, 1'b1);
    tick();
    bus.flush_i = 1'b1;
    #1;
    chk("fl_we", bus.reg_write_enable, 1'b0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("fl_busy_drop", bus.wb_busy, 1'b0);
    chk("fl_we_after", bus.reg_write_enable, 1'b0);
    tick();

    // Flush coinciding with late data
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0, 5'd11);
    tick();
    idle_in();
    tick();
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.mem_rdata_valid = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    chk("flrv_we", bus.reg_write_enable, 1'b0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("flrv_we_after", bus.reg_write_enable, 1'b0);
    chk("flrv_busy", bus.wb_busy, 1'b0);
    bus.mem_rdata_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a wait
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0, 5'd12);
    tick();
    idle_in();
    tick();
    chk("rst_wait_busy", bus.wb_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", bus.wb_busy, 1'b0);
    chk("rst_async_we", bus.reg_write_enable, 1'b0);
    chk("rst_async_addr", bus.reg_write_addr, 5'd0);
    #3 rst_n = 1'b1;
    bus.mem_rdata_valid = 1'b1;
    #1;
    chk("rst_discard_we", bus.reg_write_enable, 1'b0);
    tick();
    bus.mem_rdata_valid = 1'b0;

    // Load whose data never arrives
    present(c_MEM_ACCESS_TYPE_M2R, c_MEM_SIZE_WORD, 1'b0, 2'd0, 32'h0, 5'd13);
    tick();
    idle_in();
    #1;
    chk("to_busy_c1", bus.wb_busy, 1'b1);
    tick();
    chk("to_idle_w1", bus.load_timeout, 1'b0);
    tick();
    tick();
    tick();
`ifdef WB_LOAD_TIMEOUT_EN
    chk("to_pulse_w4", bus.load_timeout, 1'b1);
    chk("to_we_w4", bus.reg_write_enable, 1'b0);
    tick();
    chk("to_pulse_end", bus.load_timeout, 1'b0);
    chk("to_busy_rel", bus.wb_busy, 1'b0);
`else
    chk("nto_flag_w4", bus.load_timeout, 1'b0);
    chk("nto_busy_w4", bus.wb_busy, 1'b1);
    tick();
    tick();
    chk("nto_busy_w6", bus.wb_busy, 1'b1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("nto_busy_flushed", bus.wb_busy, 1'b0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
